vga_tile_compositor: RTL

- Parametrised successor of the single-board VGA pixel colouring logic.
- Composites background, snake tiles, head eyes, food glyph and N-digit score/high-score readouts into one 12-bit pixel stream with fixed latency.
- The per-pixel 100-segment scan is replaced by a tile-occupancy bitmap written through a valid/ready update port; decimal digits come from a sequential converter run once per frame.
- Sits between the VGATimingGenerator/palette RAMs and the VGA pins.

---
 rtl/vga_tile_compositor.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_tile_compositor.sv
// Three-stage VGA compositor: board tiles from an occupancy bitmap, food and eye sprites,
// and N-digit score/high-score readouts refreshed once per frame by a double-dabble converter.
module vga_tile_compositor #(
    parameter int BOARD_W    = 10,
    parameter int BOARD_H    = 10,
    parameter int TILE       = 40,
    parameter int X0         = 48,
    parameter int Y0         = 48,
    parameter int NUM_DIGITS = 3,
    parameter int GLYPH      = 50,
    parameter int SCORE_X    = 473,
    parameter int SCORE_Y    = 88,
    parameter int HS_Y       = 208,
    parameter int EYE_GLYPH  = 11,
    parameter int VAL_W      = 32
) (
    input  logic                                 clk25,
    input  logic                                 reset,
    input  logic [9:0]                           x,
    input  logic [9:0]                           y,
    input  logic                                 active,
    input  logic                                 screen_end,
    input  logic [11:0]                          bg_color,
    input  logic                                 upd_valid,
    output logic                                 upd_ready,
    input  logic [7:0]                           upd_x,
    input  logic [7:0]                           upd_y,
    input  logic                                 upd_set,
    input  logic                                 clr_req,
    input  logic [7:0]                           head_x,
    input  logic [7:0]                           head_y,
    input  logic [7:0]                           food_x,
    input  logic [7:0]                           food_y,
    input  logic [VAL_W-1:0]                     score,
    input  logic [VAL_W-1:0]                     high_score,
    input  logic                                 game_done,
    output logic [$clog2(16*GLYPH*GLYPH)-1:0]    glyph_addr,
    input  logic                                 glyph_bit,
    output logic [$clog2(TILE*TILE)-1:0]         apple_addr,
    input  logic                                 apple_bit,
    output logic [11:0]                          pix_color,
    output logic                                 pix_active
);

    localparam int N_TILES = BOARD_W * BOARD_H;
    localparam int IDX_W   = $clog2(N_TILES);
    localparam int GA_W    = $clog2(16 * GLYPH * GLYPH);
    localparam int AA_W    = $clog2(TILE * TILE);
    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int CNT_W   = $clog2(VAL_W + 1);
    localparam logic [VAL_W-1:0] LIMIT = VAL_W'(10 ** NUM_DIGITS);
    localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} conv_state_t;

    conv_state_t      state;
    logic [N_TILES-1:0] occ;
    logic             sweeping;
    logic [IDX_W-1:0] clr_idx;
    logic [BCD_W-1:0] disp_score, disp_hs, bcd_score, bcd_hs;
    logic [VAL_W-1:0] sh_score, sh_hs, prev_hs;
    logic             sat_score, sat_hs, have_prev;
    logic [CNT_W-1:0] bit_cnt;
    logic [11:0]      snake_color;

    logic             c_board, c_food, c_head, c_read, in_score, in_hs;
    logic [IDX_W-1:0] c_idx, w_idx;
    logic [GA_W-1:0]  c_gaddr;
    logic [AA_W-1:0]  c_aaddr;
    logic             w_ok;
    int               dx, dy, sx, tx, ty, ox, oy, row, pos, dig;

    logic             s0_active, s0_read, s0_food, s0_head, s0_board;
    logic [IDX_W-1:0] s0_idx;
    logic             s1_active, s1_read, s1_food, s1_head, s1_occ;

    assign upd_ready = ~sweeping;
    assign w_ok  = (int'(upd_x) < BOARD_W) && (int'(upd_y) < BOARD_H);
    assign w_idx = w_ok ? IDX_W'(int'(upd_y) * BOARD_W + int'(upd_x)) : '0;

    // Stage-0 geometry: board tile, readout digit position and the shared glyph address.
    always_comb begin
        dx = int'(x) - X0;
        dy = int'(y) - Y0;
        sx = int'(x) - SCORE_X;
        tx = dx / TILE;
        ty = dy / TILE;
        ox = dx % TILE;
        oy = dy % TILE;
        c_board  = (dx >= 0) && (dx < BOARD_W * TILE) && (dy >= 0) && (dy < BOARD_H * TILE);
        c_food   = c_board && (tx == int'(food_x)) && (ty == int'(food_y));
        c_head   = c_board && (tx == int'(head_x)) && (ty == int'(head_y));
        c_idx    = c_board ? IDX_W'(ty * BOARD_W + tx) : '0;
        in_score = (sx >= 0) && (sx < NUM_DIGITS * GLYPH) &&
                   (int'(y) >= SCORE_Y) && (int'(y) < SCORE_Y + GLYPH);
        in_hs    = (sx >= 0) && (sx < NUM_DIGITS * GLYPH) &&
                   (int'(y) >= HS_Y) && (int'(y) < HS_Y + GLYPH);
        c_read   = in_score || in_hs;
        row      = in_score ? int'(y) - SCORE_Y : int'(y) - HS_Y;
        pos      = NUM_DIGITS - 1 - sx / GLYPH;
        dig      = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i == pos)
                dig = in_score ? int'(disp_score[4*i +: 4]) : int'(disp_hs[4*i +: 4]);
        end
        if (c_read)
            c_gaddr = GA_W'(dig * GLYPH * GLYPH + row * GLYPH + sx % GLYPH);
        else if (c_board)
            c_gaddr = GA_W'(EYE_GLYPH * GLYPH * GLYPH + oy * GLYPH + ox);
        else
            c_gaddr = '0;
        c_aaddr = c_board ? AA_W'(oy * TILE + ox) : '0;
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            s0_active <= 1'b0; s0_read <= 1'b0; s0_food <= 1'b0; s0_head <= 1'b0;
            s0_board  <= 1'b0; s0_idx  <= '0;   glyph_addr <= '0; apple_addr <= '0;
            s1_active <= 1'b0; s1_read <= 1'b0; s1_food <= 1'b0; s1_head <= 1'b0;
            s1_occ    <= 1'b0; pix_active <= 1'b0; pix_color <= 12'h000;
        end else begin
            s0_active  <= active;
            s0_read    <= c_read;
            s0_food    <= c_food;
            s0_head    <= c_head;
            s0_board   <= c_board;
            s0_idx     <= c_idx;
            glyph_addr <= c_gaddr;
            apple_addr <= c_aaddr;
            s1_active  <= s0_active;
            s1_read    <= s0_read;
            s1_food    <= s0_food;
            s1_head    <= s0_head;
            s1_occ     <= s0_board & occ[s0_idx];
            pix_active <= s1_active;
            if (!s1_active)                 pix_color <= 12'h000;
            else if (s1_read)               pix_color <= glyph_bit ? 12'h000 : bg_color;
            else if (s1_food)               pix_color <= apple_bit ? 12'hF00 : bg_color;
            else if (s1_head && glyph_bit)  pix_color <= 12'h000;
            else if (s1_occ)                pix_color <= game_done ? 12'h777 : snake_color;
            else                            pix_color <= bg_color;
        end
    end

    // Reset leaves a sweep pending so the bitmap is cleared one bit per cycle after release.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            occ      <= '0;
            sweeping <= 1'b1;
            clr_idx  <= '0;
        end else begin
            if (upd_valid && upd_ready && w_ok)
                occ[w_idx] <= upd_set;
            if (clr_req) begin
                sweeping <= 1'b1;
                clr_idx  <= '0;
            end else if (sweeping) begin
                occ[clr_idx] <= 1'b0;
                if (clr_idx == IDX_W'(N_TILES - 1))
                    sweeping <= 1'b0;
                else
                    clr_idx <= clr_idx + IDX_W'(1);
            end
        end
    end

    function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b, input logic in_bit);
        logic [BCD_W-1:0] t;
        t = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (t[4*i +: 4] >= 4'd5)
                t[4*i +: 4] = t[4*i +: 4] + 4'd3;
        end
        return {t[BCD_W-2:0], in_bit};
    endfunction

    // Both readouts convert together and swap in at COMMIT so a frame never shows mixed digits.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sh_score    <= '0;
            sh_hs       <= '0;
            bcd_score   <= '0;
            bcd_hs      <= '0;
            sat_score   <= 1'b0;
            sat_hs      <= 1'b0;
            bit_cnt     <= '0;
            prev_hs     <= '0;
            have_prev   <= 1'b0;
            snake_color <= 12'h0F0;
            disp_score  <= '0;
            disp_hs     <= '0;
        end else begin
            case (state)
                IDLE: if (screen_end) state <= LOAD;
                LOAD: begin
                    sh_score  <= score;
                    sh_hs     <= high_score;
                    sat_score <= score >= LIMIT;
                    sat_hs    <= high_score >= LIMIT;
                    bcd_score <= '0;
                    bcd_hs    <= '0;
                    bit_cnt   <= '0;
                    if (have_prev && high_score != prev_hs)
                        snake_color <= {snake_color[7:0], snake_color[11:8]};
                    prev_hs   <= high_score;
                    have_prev <= 1'b1;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    bcd_score <= dabble(bcd_score, sh_score[VAL_W-1]);
                    bcd_hs    <= dabble(bcd_hs, sh_hs[VAL_W-1]);
                    sh_score  <= sh_score << 1;
                    sh_hs     <= sh_hs << 1;
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(VAL_W - 1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    disp_score <= sat_score ? ALL_NINES : bcd_score;
                    disp_hs    <= sat_hs ? ALL_NINES : bcd_hs;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
